dpram_port_initiator: RTL and testbench

Burst initiator for one valid/ready port of the team's 64×8 dual-port RAM (the responder).
- Accepts a burst command upstream and drives that many single-beat transactions onto the RAM port, with auto-incrementing address and, for writes, an incrementing fill pattern.
- Captures the RAM's one-cycle-late q into a small response FIFO and returns every beat upstream with valid/ready backpressure.
- Serves as the fill/readback engine in front of either RAM port.

---
 rtl/dpram_init_pkg.sv | 20 ++
 rtl/dpram_rsp_fifo.sv | 51 +++++
 rtl/dpram_port_initiator.sv | 160 ++++++++++++++++
 tb/tb_dpram_port_initiator.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_init_pkg.sv
// Shared types and default widths for the dual-port RAM burst initiator.
package dpram_init_pkg;

    localparam int unsigned DEF_ADDR_W    = 6;
    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_LEN_W     = 4;
    localparam int unsigned DEF_RSP_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        logic                  last;
    } rsp_t;

endpackage

// File: rtl/dpram_rsp_fifo.sv
// Small synchronous response FIFO with occupancy count; DEPTH must be a power of two.
module dpram_rsp_fifo #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned W     = 9,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [W-1:0]     i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [W-1:0]     o_data,
    output logic [PTR_W:0]   o_count
);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_pop;

    assign w_pop   = i_pop && (r_count != '0);
    assign o_valid = (r_count != '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage is cleared on reset so the head reads zero while empty after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem    <= '{default: '0};
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({i_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dpram_port_initiator.sv
// Burst initiator for one valid/ready port of the 64x8 dual-port RAM:
// issues auto-incrementing beats and returns captured q upstream through a credited FIFO.
module dpram_port_initiator
    import dpram_init_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned LEN_W     = DEF_LEN_W,
    parameter int unsigned RSP_DEPTH = DEF_RSP_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_q,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              busy
);

    localparam int unsigned PTR_W = $clog2(RSP_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned USE_W = CNT_W + 1;
    localparam int unsigned REM_W = LEN_W + 1;
    localparam int unsigned ENT_W = DATA_W + 1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_mem_valid, w_mem_valid_nxt;
    logic              r_mem_we,    w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_data,  w_mem_data_nxt;
    logic [REM_W-1:0]  r_remain,    w_remain_nxt;
    logic              r_inflight;
    logic              r_inflight_last;

    logic              w_fire;
    logic              w_pop;
    logic              w_credit_ok;
    logic [USE_W-1:0]  w_used;
    logic              w_fifo_valid;
    logic [ENT_W-1:0]  w_fifo_head;
    logic [CNT_W-1:0]  w_fifo_count;

    assign w_fire = r_mem_valid && mem_ready;
    assign w_pop  = w_fifo_valid && rsp_ready;

    // Occupancy after this edge (FIFO entries plus the beat about to be in flight) gates the next beat.
    assign w_used      = USE_W'(w_fifo_count) + USE_W'(r_inflight) + USE_W'(w_fire) - USE_W'(w_pop);
    assign w_credit_ok = (w_used < USE_W'(RSP_DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_mem_valid_nxt = r_mem_valid;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_data_nxt  = r_mem_data;
        w_remain_nxt    = r_remain;
        unique case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_state_nxt     = ISSUE;
                    w_mem_valid_nxt = 1'b1;
                    w_mem_we_nxt    = cmd_we;
                    w_mem_addr_nxt  = cmd_addr;
                    w_mem_data_nxt  = cmd_we ? cmd_data : '0;
                    w_remain_nxt    = REM_W'(cmd_len) + REM_W'(1);
                end
            end
            ISSUE: begin
                if (w_fire) begin
                    w_mem_addr_nxt = r_mem_addr + ADDR_W'(1);
                    w_mem_data_nxt = r_mem_we ? (r_mem_data + DATA_W'(1)) : '0;
                    w_remain_nxt   = r_remain - REM_W'(1);
                    if (r_remain == REM_W'(1)) begin
                        w_state_nxt     = DRAIN;
                        w_mem_valid_nxt = 1'b0;
                    end else begin
                        w_mem_valid_nxt = w_credit_ok;
                    end
                end else if (!r_mem_valid) begin
                    w_mem_valid_nxt = w_credit_ok;
                end
            end
            DRAIN: begin
                if (w_pop && w_fifo_head[0]) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Beat registers and the one-deep in-flight marker that times the q capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_valid     <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_data      <= '0;
            r_remain        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_mem_valid     <= w_mem_valid_nxt;
            r_mem_we        <= w_mem_we_nxt;
            r_mem_addr      <= w_mem_addr_nxt;
            r_mem_data      <= w_mem_data_nxt;
            r_remain        <= w_remain_nxt;
            r_inflight      <= w_fire;
            r_inflight_last <= (r_remain == REM_W'(1));
        end
    end

    dpram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .W     (ENT_W)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_inflight),
        .i_data  ({mem_q, r_inflight_last}),
        .i_pop   (rsp_ready),
        .o_valid (w_fifo_valid),
        .o_data  (w_fifo_head),
        .o_count (w_fifo_count)
    );

    assign cmd_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign mem_valid = r_mem_valid;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_data  = r_mem_data;
    assign rsp_valid = w_fifo_valid;
    assign rsp_data  = w_fifo_head[ENT_W-1:1];
    assign rsp_last  = w_fifo_head[0];

endmodule

// File: tb/tb_dpram_port_initiator.sv
// Bench for dpram_port_initiator: queue-based transaction model with a behavioural RAM,
// checked every cycle, plus directed bursts with literal expectations.
module tb_dpram_port_initiator;
    import dpram_init_pkg::*;

    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 8;
    localparam int unsigned LW    = 4;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          we;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic [DW-1:0] cmd_data;
    logic          mem_valid, mem_ready, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data, mem_q;
    logic          rsp_valid, rsp_ready, rsp_last, busy;
    logic [DW-1:0] rsp_data;

    always #5 clk = ~clk;

    dpram_port_initiator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_q     (mem_q),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: pending beats of the current burst, one in-flight beat, queued responses.
    logic [DW-1:0] ram [64];
    beat_t         m_beats [$];
    rsp_t          m_rsp [$];
    rsp_t          m_inf;
    bit            m_inf_v, m_busy, m_first;
    beat_t         beat_log [$];
    rsp_t          rsp_log [$];
    int            n_fired, acc_cyc, first_pop_cyc, last_pop_cyc;
    beat_t         b;
    rsp_t          e;
    bit            fire, pop, acc, exp_mv;
    int            outstanding;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_inf_v = 1'b0;
            m_beats.delete();
            m_rsp.delete();
            mem_q   = '0;
            check("rst_cmd_ready", cmd_ready, 1);
            check("rst_mem_valid", mem_valid, 0);
            check("rst_mem_we",    mem_we,    0);
            check("rst_mem_addr",  mem_addr,  0);
            check("rst_mem_data",  mem_data,  0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_data",  rsp_data,  0);
            check("rst_rsp_last",  rsp_last,  0);
            check("rst_busy",      busy,      0);
        end else begin
            mem_q       = m_inf_v ? m_inf.data : DW'($urandom);
            outstanding = int'(m_inf_v) + m_rsp.size();
            exp_mv      = (m_beats.size() != 0) && (outstanding < int'(DEPTH));
            check("cmd_ready", cmd_ready, !m_busy);
            check("busy",      busy,      m_busy);
            check("mem_valid", mem_valid, exp_mv);
            if (exp_mv && mem_valid) begin
                check("mem_addr", mem_addr, m_beats[0].a);
                check("mem_we",   mem_we,   m_beats[0].we);
                check("mem_data", mem_data, m_beats[0].d);
            end
            check("rsp_valid", rsp_valid, m_rsp.size() != 0);
            if (m_rsp.size() != 0 && rsp_valid) begin
                check("rsp_data", rsp_data, m_rsp[0].data);
                check("rsp_last", rsp_last, m_rsp[0].last);
            end
            fire = exp_mv && mem_ready;
            pop  = (m_rsp.size() != 0) && rsp_ready;
            acc  = !m_busy && cmd_valid;
            if (pop) begin
                e = m_rsp.pop_front();
                rsp_log.push_back(e);
                if (m_first) begin
                    first_pop_cyc = cyc;
                    m_first = 1'b0;
                end
                if (e.last) begin
                    m_busy       = 1'b0;
                    last_pop_cyc = cyc;
                end
            end
            if (m_inf_v) m_rsp.push_back(m_inf);
            m_inf_v = fire;
            if (fire) begin
                b = m_beats.pop_front();
                if (b.we) ram[b.a] = b.d;
                m_inf.data = ram[b.a];
                m_inf.last = (m_beats.size() == 0);
                beat_log.push_back(b);
                n_fired++;
            end
            if (acc) begin
                m_busy  = 1'b1;
                m_first = 1'b1;
                acc_cyc = cyc;
                for (int i = 0; i <= int'(cmd_len); i++) begin
                    b.a  = AW'(int'(cmd_addr) + i);
                    b.d  = cmd_we ? DW'(int'(cmd_data) + i) : '0;
                    b.we = cmd_we;
                    m_beats.push_back(b);
                end
            end
        end
    end

    task automatic clear_logs();
        beat_log.delete();
        rsp_log.delete();
        n_fired = 0;
    endtask

    // Call at posedge+#1; returns at posedge+#1 just after the accepting edge.
    task automatic send_cmd(input logic we, input logic [AW-1:0] a, input logic [LW-1:0] len,
                            input logic [DW-1:0] d, input bit keep);
        int n = 0;
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_len = len; cmd_data = d;
        @(negedge clk);
        while (!cmd_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        check("cmd_accept_timeout", n < 300, 1);
        @(posedge clk); #1;
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || m_busy) && n < 300) begin
            n++;
            @(negedge clk);
        end
        check("idle_timeout", n < 300, 1);
        @(posedge clk); #1;
    endtask

    task automatic chk_rsp4(input string name, input logic [DW-1:0] exp [4]);
        check({name, "_count"}, rsp_log.size(), 4);
        for (int i = 0; i < 4 && i < rsp_log.size(); i++) begin
            check($sformatf("%s_data%0d", name, i), rsp_log[i].data, exp[i]);
            check($sformatf("%s_last%0d", name, i), rsp_log[i].last, (i == 3));
        end
    endtask

    logic [AW-1:0] t1_addr [4] = '{6'h3E, 6'h3F, 6'h00, 6'h01};
    logic [DW-1:0] t1_data [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    logic [DW-1:0] t4_data [4] = '{8'h55, 8'h56, 8'h57, 8'h58};
    bit            t4_pat  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int            prev_last;

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = DW'(i * 7 + 3);
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
        cmd_data = '0; mem_ready = 1'b1; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Write burst wrapping the top of the address space
        clear_logs();
        send_cmd(1'b1, 6'h3E, 4'd3, 8'hA0, 1'b0);
        wait_idle();
        check("t1_beats", beat_log.size(), 4);
        for (int i = 0; i < 4 && i < beat_log.size(); i++) begin
            check($sformatf("t1_addr%0d", i), beat_log[i].a, t1_addr[i]);
            check($sformatf("t1_wdata%0d", i), beat_log[i].d, t1_data[i]);
        end
        chk_rsp4("t1_rsp", t1_data);

        // Read the same range back
        clear_logs();
        send_cmd(1'b0, 6'h3E, 4'd3, 8'h00, 1'b0);
        wait_idle();
        chk_rsp4("t2_rsp", t1_data);

        // Full-throughput 16-beat read: first response at T+3, last at T+18
        clear_logs();
        send_cmd(1'b0, 6'h00, 4'd15, 8'h00, 1'b0);
        wait_idle();
        check("t2b_first_lat", first_pop_cyc - acc_cyc, 3);
        check("t2b_last_lat",  last_pop_cyc - acc_cyc, 18);
        check("t2b_count",     rsp_log.size(), 16);

        // Backpressure: only RSP_DEPTH beats may fire while responses are blocked
        clear_logs();
        rsp_ready = 1'b0;
        send_cmd(1'b0, 6'h08, 4'd15, 8'h00, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        check("t3_fired_blocked", n_fired, 4);
        check("t3_mem_valid_blocked", mem_valid, 0);
        rsp_ready = 1'b1;
        wait_idle();
        check("t3_fired_total", n_fired, 16);
        check("t3_rsp_total", rsp_log.size(), 16);

        // mem_ready stalls mid-burst
        clear_logs();
        mem_ready = 1'b0;
        send_cmd(1'b1, 6'h10, 4'd3, 8'h55, 1'b0);
        for (int i = 0; i < 16; i++) begin
            mem_ready = t4_pat[i % 4];
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        wait_idle();
        chk_rsp4("t4_rsp", t4_data);

        // cmd_valid held: next command accepted the cycle after the final response pops
        clear_logs();
        send_cmd(1'b0, 6'h3E, 4'd1, 8'h00, 1'b1);
        send_cmd(1'b1, 6'h20, 4'd0, 8'h77, 1'b0);
        prev_last = last_pop_cyc;
        check("t5_back_to_back", acc_cyc - prev_last, 1);
        wait_idle();
        check("t5_rsp_count", rsp_log.size(), 3);

        // Reset after two of eight beats, then a single-beat read
        clear_logs();
        send_cmd(1'b1, 6'h1E, 4'd7, 8'hC0, 1'b0);
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b0;
        check("t6_fired_before_rst", n_fired, 2);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_logs();
        send_cmd(1'b0, 6'h1E, 4'd0, 8'h00, 1'b0);
        wait_idle();
        check("t6_rsp_count", rsp_log.size(), 1);
        if (rsp_log.size() != 0) begin
            check("t6_rsp_data", rsp_log[0].data, 8'hC0);
            check("t6_rsp_last", rsp_log[0].last, 1);
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
